// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: per-channel square wave and tick,
// with divisors reloaded through a valid/ready port at the next period boundary.
module clock_divider_multi #(
  parameter int unsigned SYS_FREQUENCY = 50_000_000,
  parameter int unsigned CH            = 4,
  parameter int unsigned CW            = 26,
  parameter int unsigned DEFAULT_DIV   = 50_000_000,
  localparam int unsigned LW           = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic [CH-1:0] ch_en,
  input  logic          load_valid,
  input  logic [LW-1:0] load_ch,
  input  logic [CW-1:0] load_div,
  output logic          load_ready,
  output logic          load_err,
  output logic [CH-1:0] clk_div,
  output logic [CH-1:0] tick
);

  // Elaboration-time sanity checks on the configuration.
  if (SYS_FREQUENCY == 0) begin : g_bad_freq
    $error("clock_divider_multi: SYS_FREQUENCY must be non-zero");
  end
  if (CH < 1 || CH > 16) begin : g_bad_ch
    $error("clock_divider_multi: CH must be within 1..16");
  end
  if (DEFAULT_DIV < 2 || DEFAULT_DIV > ((64'd1 << CW) - 64'd1)) begin : g_bad_div
    $error("clock_divider_multi: DEFAULT_DIV must be within 2..2^CW-1");
  end

  logic [CW-1:0] cnt_q    [CH];
  logic [CW-1:0] cnt_d    [CH];
  logic [CW-1:0] period_q [CH];
  logic [CW-1:0] period_d [CH];
  logic [CW-1:0] staged_q [CH];
  logic [CW-1:0] staged_d [CH];
  logic [CH-1:0] pending_q, pending_d;
  logic [CH-1:0] clk_div_q, clk_div_d;
  logic [CH-1:0] tick_q,    tick_d;
  logic          load_err_q, load_err_d;

  logic          ready_c;
  logic          ch_ok_c;
  logic          div_ok_c;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(CH); i++) begin
        cnt_q[i]    <= CW'(DEFAULT_DIV - 1);
        period_q[i] <= CW'(DEFAULT_DIV);
        staged_q[i] <= '0;
      end
      pending_q  <= '0;
      clk_div_q  <= '0;
      tick_q     <= '0;
      load_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(CH); i++) begin
        cnt_q[i]    <= cnt_d[i];
        period_q[i] <= period_d[i];
        staged_q[i] <= staged_d[i];
      end
      pending_q  <= pending_d;
      clk_div_q  <= clk_div_d;
      tick_q     <= tick_d;
      load_err_q <= load_err_d;
    end
  end

  // Ready is looked up per target channel; nonexistent channels report ready
  // so that a request to them is answered with an error instead of a stall.
  always_comb begin
    ready_c = 1'b1;
    for (int i = 0; i < int'(CH); i++) begin
      if (load_ch == LW'(i)) ready_c = !pending_q[i];
    end
  end

  assign ch_ok_c  = (32'(load_ch) < CH);
  assign div_ok_c = (load_div >= CW'(2));

  always_comb begin
    pending_d  = pending_q;
    clk_div_d  = '0;
    tick_d     = '0;
    load_err_d = 1'b0;
    for (int i = 0; i < int'(CH); i++) begin
      cnt_d[i]    = cnt_q[i];
      period_d[i] = period_q[i];
      staged_d[i] = staged_q[i];
    end

    for (int i = 0; i < int'(CH); i++) begin
      if (!ch_en[i]) begin
        // Parked at the wrap point so re-enabling starts a fresh period.
        if (pending_q[i]) begin
          period_d[i]  = staged_q[i];
          pending_d[i] = 1'b0;
        end
        cnt_d[i] = period_d[i] - CW'(1);
      end else if (cnt_q[i] == period_q[i] - CW'(1)) begin
        cnt_d[i]     = '0;
        tick_d[i]    = 1'b1;
        clk_div_d[i] = 1'b1;
        if (pending_q[i]) begin
          period_d[i]  = staged_q[i];
          pending_d[i] = 1'b0;
        end
      end else begin
        cnt_d[i]     = cnt_q[i] + CW'(1);
        clk_div_d[i] = (cnt_q[i] + CW'(1)) < (period_q[i] >> 1);
      end
    end

    // A load only lands on a channel whose pending flag was clear, so it
    // never collides with the wrap/park update above.
    if (load_valid && ready_c) begin
      if (div_ok_c && ch_ok_c) begin
        for (int i = 0; i < int'(CH); i++) begin
          if (load_ch == LW'(i)) begin
            staged_d[i]  = load_div;
            pending_d[i] = 1'b1;
          end
        end
      end else begin
        load_err_d = 1'b1;
      end
    end
  end

  assign load_ready = ready_c;
  assign load_err   = load_err_q;
  assign clk_div    = clk_div_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: directed scenarios plus random traffic,
// checked every cycle against a phase-based reference model.
module tb_clock_divider_multi;

  localparam int unsigned CH  = 5;
  localparam int unsigned CW  = 8;
  localparam int unsigned DD  = 4;
  localparam int unsigned LW  = 3;

  logic          clk_in = 1'b0;
  logic          rst;
  logic [CH-1:0] ch_en;
  logic          load_valid;
  logic [LW-1:0] load_ch;
  logic [CW-1:0] load_div;
  logic          load_ready;
  logic          load_err;
  logic [CH-1:0] clk_div;
  logic [CH-1:0] tick;

  clock_divider_multi #(
    .SYS_FREQUENCY(50_000_000),
    .CH(CH),
    .CW(CW),
    .DEFAULT_DIV(DD)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .ch_en(ch_en),
    .load_valid(load_valid),
    .load_ch(load_ch),
    .load_div(load_div),
    .load_ready(load_ready),
    .load_err(load_err),
    .clk_div(clk_div),
    .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  // Reference model: position within the period, plus a flag telling whether
  // the channel is mid-period (run) or waiting to start on the next edge.
  int unsigned   m_per [CH];
  int unsigned   m_stg [CH];
  int unsigned   m_ph  [CH];
  bit            m_pend[CH];
  bit            m_run [CH];
  bit [CH-1:0]   m_clk;
  bit [CH-1:0]   m_tick;
  bit            m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready(input int unsigned lc);
    if (lc >= CH) return 1'b1;
    return !m_pend[lc];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(CH); i++) begin
      m_per[i]  = DD;
      m_stg[i]  = 0;
      m_ph[i]   = 0;
      m_pend[i] = 1'b0;
      m_run[i]  = 1'b0;
    end
    m_clk  = '0;
    m_tick = '0;
    m_err  = 1'b0;
  endtask

  task automatic model_edge();
    int unsigned lc;
    int unsigned ld;
    bit          rdy;
    lc  = int'(load_ch);
    ld  = int'(load_div);
    rdy = exp_ready(lc);
    for (int i = 0; i < int'(CH); i++) begin
      if (!ch_en[i]) begin
        if (m_pend[i]) begin
          m_per[i]  = m_stg[i];
          m_pend[i] = 1'b0;
        end
        m_run[i]  = 1'b0;
        m_clk[i]  = 1'b0;
        m_tick[i] = 1'b0;
      end else begin
        if (!m_run[i] || (m_ph[i] + 1 == m_per[i])) begin
          m_ph[i] = 0;
          if (m_pend[i]) begin
            m_per[i]  = m_stg[i];
            m_pend[i] = 1'b0;
          end
          m_run[i]  = 1'b1;
          m_tick[i] = 1'b1;
        end else begin
          m_ph[i]   = m_ph[i] + 1;
          m_tick[i] = 1'b0;
        end
        m_clk[i] = (m_ph[i] < m_per[i] / 2);
      end
    end
    m_err = 1'b0;
    if (load_valid && rdy) begin
      if (ld >= 2 && lc < CH) begin
        m_stg[lc]  = ld;
        m_pend[lc] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk_in);
    model_edge();
    #1;
    chk({tag, ".clk_div"},  32'(clk_div),  32'(m_clk));
    chk({tag, ".tick"},     32'(tick),     32'(m_tick));
    chk({tag, ".load_err"}, 32'(load_err), 32'(m_err));
  endtask

  task automatic drive(input logic [CH-1:0] en, input logic lv,
                       input logic [LW-1:0] lc, input logic [CW-1:0] ld);
    ch_en      = en;
    load_valid = lv;
    load_ch    = lc;
    load_div   = ld;
    #1;
    chk("load_ready", 32'(load_ready), 32'(exp_ready(int'(lc))));
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  initial begin
    rst        = 1'b0;
    ch_en      = '0;
    load_valid = 1'b0;
    load_ch    = '0;
    load_div   = '0;
    model_reset();
    #12;
    chk("reset.clk_div",  32'(clk_div),  32'd0);
    chk("reset.tick",     32'(tick),     32'd0);
    chk("reset.load_err", 32'(load_err), 32'd0);
    rst = 1'b1;

    // 1: only ch0 runs at the default period
    drive(5'b00001, 1'b0, 3'd0, 8'd0);
    run("t1", 12);

    // 2: reload ch0 to P=5, ready drops until the boundary
    drive(5'b00001, 1'b1, 3'd0, 8'd5);
    step("t2.load");
    drive(5'b00001, 1'b0, 3'd0, 8'd0);
    run("t2", 14);

    // 3: illegal loads raise load_err without changing state
    drive(5'b00001, 1'b1, 3'd0, 8'd1);
    step("t3.div1");
    drive(5'b00001, 1'b1, 3'd1, 8'd0);
    step("t3.div0");
    drive(5'b00001, 1'b1, 3'd5, 8'd6);
    step("t3.ch5");
    drive(5'b00001, 1'b1, 3'd7, 8'd6);
    step("t3.ch7");
    drive(5'b00001, 1'b0, 3'd0, 8'd0);
    run("t3", 6);

    // 4: second load to a pending channel is refused; another channel accepts
    drive(5'b01101, 1'b0, 3'd0, 8'd0);
    run("t4.pre", 4);
    drive(5'b01101, 1'b1, 3'd2, 8'd6);
    step("t4.ld2a");
    drive(5'b01101, 1'b1, 3'd2, 8'd9);
    step("t4.ld2b");
    drive(5'b01101, 1'b1, 3'd3, 8'd7);
    step("t4.ld3");
    drive(5'b01101, 1'b0, 3'd0, 8'd0);
    run("t4", 16);

    // 5: ch1 at P=10, disable mid-period, load P=3 while parked, re-enable
    drive(5'b00011, 1'b1, 3'd1, 8'd10);
    step("t5.ld10");
    drive(5'b00011, 1'b0, 3'd0, 8'd0);
    run("t5.run10", 11);
    drive(5'b00001, 1'b1, 3'd1, 8'd3);
    step("t5.off");
    drive(5'b00001, 1'b0, 3'd0, 8'd0);
    run("t5.parked", 2);
    drive(5'b00011, 1'b0, 3'd0, 8'd0);
    run("t5.run3", 10);

    // Random traffic: enable toggles and loads of every flavour
    for (int k = 0; k < 2000; k++) begin
      logic [CH-1:0] en;
      en = ch_en;
      if ($urandom_range(0, 7) == 0) en = CH'($urandom);
      drive(en, ($urandom_range(0, 2) == 0), LW'($urandom_range(0, 7)),
            CW'($urandom_range(0, 12)));
      step("rand");
    end

    // 6: asynchronous reset mid-period with a load pending
    drive(5'b11111, 1'b0, 3'd0, 8'd0);
    run("t6.pre", 6);
    drive(5'b11111, 1'b1, 3'd4, 8'd7);
    step("t6.ld");
    drive(5'b11111, 1'b0, 3'd0, 8'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("t6.async.clk_div",  32'(clk_div),  32'd0);
    chk("t6.async.tick",     32'(tick),     32'd0);
    chk("t6.async.load_err", 32'(load_err), 32'd0);
    model_reset();
    chk("t6.async.ready4", 32'(load_ready), 32'(exp_ready(0)));
    #2;
    rst = 1'b1;
    run("t6.post", 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
